// File: rtl/diff_commit_packer.sv
// Difftest commit packer: buffers retired records and emits them in program order as
// commit slots plus at most one store event or one lone exception event per cycle.
// Optional stall counter output enabled by the DIFF_PACK_STALL_CNT_EN macro.
module diff_commit_packer #(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COMMIT_W-1:0]     in_valid,
    output logic                    in_ready,
    input  logic [64*COMMIT_W-1:0]  in_pc,
    input  logic [32*COMMIT_W-1:0]  in_instr,
    input  logic [COMMIT_W-1:0]     in_wen,
    input  logic [8*COMMIT_W-1:0]   in_wdest,
    input  logic [64*COMMIT_W-1:0]  in_wdata,
    input  logic [COMMIT_W-1:0]     in_skip,
    input  logic [8*COMMIT_W-1:0]   in_st_valid,
    input  logic [64*COMMIT_W-1:0]  in_st_paddr,
    input  logic [64*COMMIT_W-1:0]  in_st_vaddr,
    input  logic [64*COMMIT_W-1:0]  in_st_data,
    input  logic [COMMIT_W-1:0]     in_excp,
    input  logic [COMMIT_W-1:0]     in_eret,
    input  logic [11*COMMIT_W-1:0]  in_intrNo,
    input  logic [6*COMMIT_W-1:0]   in_cause,
    output logic [COMMIT_W-1:0]     out_valid,
    output logic [8*COMMIT_W-1:0]   out_index,
    output logic [64*COMMIT_W-1:0]  out_pc,
    output logic [32*COMMIT_W-1:0]  out_instr,
    output logic [COMMIT_W-1:0]     out_wen,
    output logic [8*COMMIT_W-1:0]   out_wdest,
    output logic [64*COMMIT_W-1:0]  out_wdata,
    output logic [COMMIT_W-1:0]     out_skip,
    output logic [7:0]              storeValid,
    output logic [7:0]              storeIndex,
    output logic [63:0]             storePaddr,
    output logic [63:0]             storeVaddr,
    output logic [63:0]             storeData,
    output logic                    excp_valid,
    output logic                    eret,
    output logic [10:0]             intrNo,
    output logic [5:0]              cause,
    output logic [31:0]             exceptionPC,
`ifdef DIFF_PACK_STALL_CNT_EN
    output logic [31:0]             stall_cycles,
`endif
    output logic [31:0]             exceptionInst
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SLOT_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic        skip;
        logic [7:0]  st_valid;
        logic [63:0] st_paddr;
        logic [63:0] st_vaddr;
        logic [63:0] st_data;
        logic        excp;
        logic        eret;
        logic [10:0] intr_no;
        logic [5:0]  cause;
    } rec_t;

    rec_t mem [DEPTH];
    rec_t lane_rec [COMMIT_W];
    rec_t head_rec [COMMIT_W];

    logic [PTR_W-1:0]      rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [CNT_W-1:0]      n_push, n_pop;
    logic                  in_ready_reg;
    logic [7:0]            commit_cnt_reg, store_cnt_reg;

    logic [COMMIT_W-1:0]   slot_take;
    logic                  take_excp, has_store, eret_any, scan_stop;
    logic [SLOT_W-1:0]     store_slot;

    logic [COMMIT_W-1:0]   out_valid_reg, out_wen_reg, out_skip_reg;
    logic [8*COMMIT_W-1:0] out_index_reg, out_wdest_reg;
    logic [64*COMMIT_W-1:0] out_pc_reg, out_wdata_reg;
    logic [32*COMMIT_W-1:0] out_instr_reg;
    logic [7:0]            store_valid_reg, store_index_reg;
    logic [63:0]           store_paddr_reg, store_vaddr_reg, store_data_reg;
    logic                  excp_valid_reg, eret_reg;
    logic [10:0]           intr_no_reg;
    logic [5:0]            cause_reg;
    logic [31:0]           exception_pc_reg, exception_inst_reg;

    for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_lane
        assign lane_rec[gi] = '{
            pc:       in_pc[64*gi +: 64],
            instr:    in_instr[32*gi +: 32],
            wen:      in_wen[gi],
            wdest:    in_wdest[8*gi +: 8],
            wdata:    in_wdata[64*gi +: 64],
            skip:     in_skip[gi],
            st_valid: in_st_valid[8*gi +: 8],
            st_paddr: in_st_paddr[64*gi +: 64],
            st_vaddr: in_st_vaddr[64*gi +: 64],
            st_data:  in_st_data[64*gi +: 64],
            excp:     in_excp[gi],
            eret:     in_eret[gi],
            intr_no:  in_intrNo[11*gi +: 11],
            cause:    in_cause[6*gi +: 6]
        };
        assign head_rec[gi] = mem[rd_ptr_reg + PTR_W'(gi)];
    end

    // Lanes are contiguous from lane 0, so lane i lands at wr_ptr + i.
    always_ff @(posedge clock) begin
        for (int i = 0; i < COMMIT_W; i++) begin
            if (in_ready_reg && in_valid[i]) begin
                mem[wr_ptr_reg + PTR_W'(i)] <= lane_rec[i];
            end
        end
    end

    always_comb begin
        n_push = '0;
        if (in_ready_reg) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (in_valid[i]) begin
                    n_push = n_push + CNT_W'(1);
                end
            end
        end
    end

    // Head exception pops alone; otherwise scan in order, stopping at an
    // exception or at a second store.
    always_comb begin
        slot_take  = '0;
        take_excp  = 1'b0;
        has_store  = 1'b0;
        store_slot = '0;
        eret_any   = 1'b0;
        n_pop      = '0;
        scan_stop  = 1'b0;
        if (count_reg != '0 && head_rec[0].excp) begin
            take_excp = 1'b1;
            n_pop     = CNT_W'(1);
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (!scan_stop) begin
                    if (k >= int'(count_reg) || head_rec[k].excp ||
                        (has_store && head_rec[k].st_valid != '0)) begin
                        scan_stop = 1'b1;
                    end else begin
                        slot_take[k] = 1'b1;
                        n_pop        = n_pop + CNT_W'(1);
                        eret_any     = eret_any | head_rec[k].eret;
                        if (head_rec[k].st_valid != '0) begin
                            has_store  = 1'b1;
                            store_slot = SLOT_W'(k);
                        end
                    end
                end
            end
        end
    end

    assign count_next = count_reg + n_push - n_pop;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_reg         <= '0;
            wr_ptr_reg         <= '0;
            count_reg          <= '0;
            in_ready_reg       <= 1'b0;
            commit_cnt_reg     <= '0;
            store_cnt_reg      <= '0;
            out_valid_reg      <= '0;
            out_index_reg      <= '0;
            out_pc_reg         <= '0;
            out_instr_reg      <= '0;
            out_wen_reg        <= '0;
            out_wdest_reg      <= '0;
            out_wdata_reg      <= '0;
            out_skip_reg       <= '0;
            store_valid_reg    <= '0;
            store_index_reg    <= '0;
            store_paddr_reg    <= '0;
            store_vaddr_reg    <= '0;
            store_data_reg     <= '0;
            excp_valid_reg     <= 1'b0;
            eret_reg           <= 1'b0;
            intr_no_reg        <= '0;
            cause_reg          <= '0;
            exception_pc_reg   <= '0;
            exception_inst_reg <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_reg + PTR_W'(n_pop);
            wr_ptr_reg   <= wr_ptr_reg + PTR_W'(n_push);
            count_reg    <= count_next;
            in_ready_reg <= (int'(count_next) <= DEPTH - COMMIT_W);
            if (!take_excp) begin
                commit_cnt_reg <= commit_cnt_reg + 8'(n_pop);
            end
            if (has_store) begin
                store_cnt_reg <= store_cnt_reg + 8'd1;
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                out_valid_reg[k]         <= slot_take[k];
                out_index_reg[8*k +: 8]  <= commit_cnt_reg + 8'(k);
                out_pc_reg[64*k +: 64]   <= slot_take[k] ? head_rec[k].pc    : '0;
                out_instr_reg[32*k +: 32] <= slot_take[k] ? head_rec[k].instr : '0;
                out_wen_reg[k]           <= slot_take[k] & head_rec[k].wen;
                out_wdest_reg[8*k +: 8]  <= slot_take[k] ? head_rec[k].wdest : '0;
                out_wdata_reg[64*k +: 64] <= slot_take[k] ? head_rec[k].wdata : '0;
                out_skip_reg[k]          <= slot_take[k] & head_rec[k].skip;
            end
            store_valid_reg    <= has_store ? head_rec[store_slot].st_valid : '0;
            store_index_reg    <= has_store ? store_cnt_reg : '0;
            store_paddr_reg    <= has_store ? head_rec[store_slot].st_paddr : '0;
            store_vaddr_reg    <= has_store ? head_rec[store_slot].st_vaddr : '0;
            store_data_reg     <= has_store ? head_rec[store_slot].st_data : '0;
            excp_valid_reg     <= take_excp;
            eret_reg           <= eret_any;
            intr_no_reg        <= take_excp ? head_rec[0].intr_no : '0;
            cause_reg          <= take_excp ? head_rec[0].cause : '0;
            exception_pc_reg   <= take_excp ? head_rec[0].pc[31:0] : '0;
            exception_inst_reg <= take_excp ? head_rec[0].instr : '0;
        end
    end

`ifdef DIFF_PACK_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (!in_ready_reg && in_valid != '0 && stall_cnt_reg != 32'hFFFF_FFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_reg;
`endif

    assign in_ready      = in_ready_reg;
    assign out_valid     = out_valid_reg;
    assign out_index     = out_index_reg;
    assign out_pc        = out_pc_reg;
    assign out_instr     = out_instr_reg;
    assign out_wen       = out_wen_reg;
    assign out_wdest     = out_wdest_reg;
    assign out_wdata     = out_wdata_reg;
    assign out_skip      = out_skip_reg;
    assign storeValid    = store_valid_reg;
    assign storeIndex    = store_index_reg;
    assign storePaddr    = store_paddr_reg;
    assign storeVaddr    = store_vaddr_reg;
    assign storeData     = store_data_reg;
    assign excp_valid    = excp_valid_reg;
    assign eret          = eret_reg;
    assign intrNo        = intr_no_reg;
    assign cause         = cause_reg;
    assign exceptionPC   = exception_pc_reg;
    assign exceptionInst = exception_inst_reg;
endmodule
